// File: rtl/shift_reg_tx.sv
// Parallel-in, serial-out transmitter for an external 74HC595-style shift-register chain.
// A word accepted on start is shifted out on sdo with a divided shift clock (sclk), then
// strobed into the storage register with a latch pulse. All outputs are registered.
module shift_reg_tx #(
  parameter int unsigned N         = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         busy,
  output logic         done,
  output logic         sdo,
  output logic         sclk,
  output logic         latch
);

  localparam int unsigned BitW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BitW-1:0] BitLast = BitW'(N - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLow   = 2'd1;
  localparam logic [1:0] StHigh  = 2'd2;
  localparam logic [1:0] StLatch = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [N-1:0]    shreg_shift;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sdo_q, sdo_d;
  logic            sclk_q, sclk_d;
  logic            latch_q, latch_d;

  // The bit presented on sdo is always the one at the outgoing end of the register.
  function automatic logic first_bit(input logic [N-1:0] w);
    return (MSB_FIRST != 0) ? w[N-1] : w[0];
  endfunction

  // Next-state logic: every output is computed here and registered, so sdo moves on the
  // same edge that sclk falls and nothing reaches the pins combinationally.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sdo_d       = sdo_q;
    sclk_d      = sclk_q;
    latch_d     = latch_q;
    shreg_shift = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    case (state_q)
      StIdle: begin
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        sdo_d   = 1'b0;
        if (start) begin
          shreg_d   = data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          busy_d    = 1'b1;
          sdo_d     = first_bit(data);
          state_d   = StLow;
        end
      end
      StLow: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          state_d   = StHigh;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          if (bit_cnt_q == BitLast) begin
            // Last bit stays on sdo through the latch pulse.
            latch_d = 1'b1;
            state_d = StLatch;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_shift;
            sdo_d     = first_bit(shreg_shift);
            state_d   = StLow;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (div_cnt_q == DivLast) begin
          div_cnt_d = '0;
          latch_d   = 1'b0;
          busy_d    = 1'b0;
          sdo_d     = 1'b0;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sdo_q     <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sdo_q     <= sdo_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sdo   = sdo_q;
  assign sclk  = sclk_q;
  assign latch = latch_q;

endmodule

// File: doc/shift_reg_tx.md
Name: shift_reg_tx

Overview:
- Parallel-in, serial-out transmitter: the writer side of the serial shift-register interface.
- Takes an N-bit word through a start/busy handshake.
- Drives a serial data line, a divided shift clock and a latch strobe for an external shift-register chain (74HC595-style LED/segment driver, or our own serial-in shift register).
- Sits between a control FSM or debounced button logic and the board header.

Parameters:
- N, 8: word width, in bits shifted per transfer; must be >= 1.
- CLK_DIV, 4: system clocks per sclk half-period, and the latch pulse length; must be >= 1.
- MSB_FIRST, 1: 1 = data[N-1] is shifted first; 0 = data[0] is shifted first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  transfer request, sampled only in IDLE.
- data  input  N  parallel word, captured on the accepted start cycle.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- sdo  output  1  serial data out.
- sclk  output  1  shift clock; external device samples sdo on its rising edge.
- latch  output  1  storage-register strobe, active-high.

Behaviour:
- Reset: synchronous, active-high. While rst=1 at a clk edge, the next state is:
  - FSM in IDLE;
  - busy=0, done=0, sdo=0, sclk=0, latch=0;
  - shift register and counters cleared.
- Reset mid-transfer aborts immediately: no further sclk edges, no latch pulse, no done pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, LOW, HIGH, LATCH.
- IDLE:
  - busy=0, sclk=0, latch=0.
  - If start=1: capture data into the shift register, clear the bit counter and the divider counter, and go to LOW.
  - busy=1, and sdo = first bit, from the next cycle.
  - data is ignored outside the accepted start cycle.
- LOW:
  - sclk=0 for exactly CLK_DIV cycles.
  - sdo holds the current bit for the whole LOW+HIGH period.
  - Then go to HIGH.
- HIGH:
  - sclk=1 for exactly CLK_DIV cycles.
  - At the end of HIGH:
    - If bit counter = N-1: go to LATCH, with sdo held at the last bit.
    - Otherwise: increment the counter, shift the register so the next bit appears on sdo, and go to LOW.
  - sdo changes only on the same edge sclk falls. This gives CLK_DIV cycles of setup and of hold around each rising edge.
- LATCH:
  - sclk=0, latch=1 for exactly CLK_DIV cycles.
  - Then go to IDLE with busy=0 and latch=0, and done=1 for that single first IDLE cycle.
- Transfer length: busy is high for exactly 2*CLK_DIV*N + CLK_DIV cycles. There are exactly N sclk rising edges and one latch pulse per transfer.
- start while busy=1 is ignored: it is not queued and does not change the captured word.
- start=1 in the done cycle is accepted (the FSM is in IDLE), giving back-to-back transfers. busy is low for only that one cycle.
- start held high continuously gives a new transfer after every done.
- sdo returns to 0 in IDLE.
- Counter widths: bit counter is clog2(N) with a minimum of 1; divider is clog2(CLK_DIV) with a minimum of 1.
- Both counters count from 0 to limit-1 and never wrap silently: each terminal count forces a state change.
- N=1 and CLK_DIV=1 are legal. The CLK_DIV=1 case is sclk toggling every cycle, with a 1-cycle latch.

Test Plan:
- Basic transfer, N=8, CLK_DIV=2, MSB_FIRST=1, data=0xA5, one-cycle start:
  - sdo sampled at the 8 sclk rises reads 1,0,1,0,0,1,0,1;
  - latch high for 2 cycles after the 8th HIGH;
  - busy high for 34 cycles;
  - done high for exactly 1 cycle, with busy=0 in that cycle.
- Same stimulus with MSB_FIRST=0: the sampled sequence is 1,0,1,0,0,1,0,1 reversed bit order of 0xA5, i.e. 1,0,1,0,0,1,0,1 for LSB-first. Repeat with data=0x01 to distinguish: MSB_FIRST=1 gives 0,0,0,0,0,0,0,1; MSB_FIRST=0 gives 1,0,0,0,0,0,0,0.
- Busy-ignore: start=1 with data=0x0F; then start=1 with data=0xFF at cycle 10 → the shifted word is still 0x0F, and there is exactly one latch pulse.
- Back-to-back: start held high, data=0x3C, then 0xC3 applied at the done cycle → two complete transfers with busy low for 1 cycle between them. The second word is 0xC3; there are 16 sclk rises and 2 latch pulses in total.
- Reset mid-transfer: rst=1 for one cycle after the 3rd sclk rise → the next cycle has all outputs 0. There are no further sclk edges, no latch, and no done. A subsequent start with data=0x81 produces a normal full transfer.
- Edge parameters N=1, CLK_DIV=1, data=1: sclk is 0,1 for one cycle each; sdo=1; latch for 1 cycle; busy for 3 cycles; done pulse.
